instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Read-side initiator for the 256x16 instruction ROM. Owns the program counter, drives
//   the ROM address, captures each returned instruction with its PC into a small
//   prefetch queue and presents it to decode with a valid/ready handshake.
//   Handles branch/jump redirects (queue flush) and stops fetching after a HALT opcode.
// PARAMETERS
//   ADDR_W      8      ROM address / PC width; PC wraps modulo 2**ADDR_W
//   INSTR_W     16     instruction width
//   DEPTH       2      prefetch queue entries (power of two, >=2)
//   RESET_PC    8'h00  PC value loaded on reset
//   HALT_OPC    4'hF   opcode (instr[15:12]) that stops fetching
// PORTS
//   clk             in   1        single clock, rising edge
//   rst_n           in   1        asynchronous, active-low reset
//   start           in   1        pulse: IDLE/HALT -> RUN (PC unchanged)
//   imem_addr       out  ADDR_W   ROM address, equal to the PC register
//   imem_instr      in   INSTR_W  ROM data; combinational from imem_addr, same cycle
//   redirect_valid  in   1        load redirect_pc, flush queue
//   redirect_pc     in   ADDR_W   new fetch address
//   out_valid       out  1        queue head valid
//   out_ready       in   1        decode accepts head
//   out_instr       out  INSTR_W  head instruction
//   out_pc          out  ADDR_W   PC of head instruction
//   halted          out  1        high in HALT state
// BEHAVIOUR
//   Reset (async assert, sync release): PC=RESET_PC, queue empty, state IDLE;
//     imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
//   States: IDLE -(start)-> RUN; RUN -(HALT pushed)-> HALT; HALT -(start)-> RUN;
//     any state -(redirect_valid)-> RUN. start while in RUN is ignored.
//   pop  = out_valid & out_ready.
//   push = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
//   On push: enqueue {PC, imem_instr}; PC <= PC+1 (255 -> 0 wrap, no flag).
//   If pushed imem_instr[15:12]==HALT_OPC: state -> HALT next cycle; PC advances past it;
//     no further pushes; queued entries (incl. HALT) still drain via handshake.
//   halted asserts the cycle after the HALT entry is pushed; clears on start/redirect.
//   Redirect has top priority: next cycle PC=redirect_pc, count=0, no push this cycle.
//     A pop in the same cycle as redirect is a completed transfer; the rest is discarded.
//     Redirect during IDLE/HALT also loads PC and enters RUN.
//   Full queue with pop: push and pop both occur, count unchanged.
//   Empty queue: out_valid=0; out_instr/out_pc hold last value (don't-care).
//   Latency: start in cycle N -> RUN at N+1 -> push at end of N+1 -> out_valid at N+2.
//     Redirect in cycle N -> first new entry out_valid at N+2.
//   Throughput: one instruction per cycle with out_ready held high.
//   out_instr/out_pc/out_valid come from registers only; no comb path from out_ready,
//     redirect or imem_instr to outputs.
//   Reset asserted mid-operation: immediate return to reset values, pending entries lost.
// TESTING
//   1 Reset, ROM[0..3]=ADD,SUB,LOAD,STORE, start, ready=1 -> out_pc 0,1,2,3 on consecutive
//     cycles from start+2; out_instr matches ROM.
//   2 ready=0 for 5 cycles after start -> count saturates at DEPTH, PC=2, imem_addr stable;
//     release ready -> pcs 0,1,2,... with no loss or duplication.
//   3 Redirect to 8'h40 while queue full and ready=1 -> head popped that cycle, remaining
//     flushed, next out_pc=8'h40 two cycles later.
//   4 ROM[5]=16'hF000 -> entries 0..5 delivered, halted=1, PC=6, no out_valid after PC 5;
//     start -> fetch resumes at PC 6.
//   5 Redirect to 8'hFE, run -> out_pc FE, FF, 00, 01 (wrap).
//   6 Assert rst_n=0 asynchronously mid-run with queue non-empty -> out_valid=0,
//     imem_addr=RESET_PC immediately; state IDLE after release until start.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: ROM read port plus decode-side valid/ready channel of the fetch unit
interface instruction_fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   modport master (output imem_addr, out_valid, out_instr, out_pc, input imem_instr, out_ready);
   modport slave  (input imem_addr, out_valid, out_instr, out_pc, output imem_instr, out_ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and ROM reader feeding a small prefetch queue to decode,
// with redirect flush and stop-after-HALT.
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OPC = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_halted,
   instruction_fetch_unit_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t             r_state, w_next;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
   logic [INSTR_W-1:0] r_q_instr [DEPTH];
   logic [PW-1:0]      r_rd, r_wr;
   logic [CW-1:0]      r_count;
   logic               w_pop, w_push, w_halt;
   assign bus.imem_addr = r_pc;
   assign bus.out_valid = r_count != '0;
   assign bus.out_instr = r_q_instr[r_rd];
   assign bus.out_pc    = r_q_pc[r_rd];
   assign o_halted      = r_state == HALT;
   assign w_pop  = bus.out_valid & bus.out_ready;
   assign w_push = (r_state == RUN) & ~i_redirect_valid & ((r_count < CW'(DEPTH)) | w_pop);
   assign w_halt = bus.imem_instr[INSTR_W-1 -: 4] == HALT_OPC;
   always_comb begin
      w_next = i_redirect_valid                ? RUN  :
               (r_state != RUN && i_start)      ? RUN  :
               (w_push && w_halt)               ? HALT : r_state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_q_pc[k]    <= '0;
            r_q_instr[k] <= '0;
         end
      end else if (i_redirect_valid) begin
         // a same-cycle pop has completed; everything else queued is dropped
         r_pc    <= i_redirect_pc;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wr]    <= r_pc;
            r_q_instr[r_wr] <= bus.imem_instr;
            r_wr            <= r_wr + PW'(1);
            r_pc            <= r_pc + ADDR_W'(1);
         end
         if (w_pop) r_rd <= r_rd + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule
